// File: rtl/apb_slave_bank_pkg.sv
// Shared FSM encoding and address-decode constants for the APB register bank.
// Combinational only: no latency, no flow control of its own.
package apb_slave_bank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_e;

  localparam int WORD_LSB = 2;
  localparam int CNT_W    = 4;

  function automatic int idx_width(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/apb_reg_bank.sv
// DEPTH x DATA_WIDTH register array: one synchronous write port, combinational read.
// Write takes effect at the next rising edge; read is zero-latency; never stalls.
module apb_reg_bank
  import apb_slave_bank_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int IDX_W      = idx_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  we_i,
  input  logic [IDX_W-1:0]      waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [IDX_W-1:0]      raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave_bank.sv
// APB slave fronting NUM_SLAVES register banks; Pready after WAIT_CYCLES+1 access cycles.
// Backpressure via Pready wait states; a dropped Pselx aborts the transfer with no write.
module apb_slave_bank
  import apb_slave_bank_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int NUM_SLAVES  = 3,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  Hclk,
  input  logic                  Hresetn,
  input  logic [NUM_SLAVES-1:0] Pselx,
  input  logic                  Penable,
  input  logic                  Pwrite,
  input  logic [ADDR_WIDTH-1:0] Paddr,
  input  logic [DATA_WIDTH-1:0] Pwdata,
  output logic [DATA_WIDTH-1:0] Prdata,
  output logic                  Pready,
  output logic                  Pslverr
);

  localparam int IDX_W   = idx_width(DEPTH);
  localparam int ADDR_HI = WORD_LSB + IDX_W;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [NUM_SLAVES-1:0] sel_q, sel_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  write_q, write_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d;
  logic                  pready_q, pready_d;
  logic                  pslverr_q, pslverr_d;

  logic                  setup, addr_err, bank_we;
  logic [IDX_W-1:0]      paddr_idx, rd_idx;
  logic [NUM_SLAVES-1:0] rd_sel;
  logic [DATA_WIDTH-1:0] bank_rdata [NUM_SLAVES];
  logic [DATA_WIDTH-1:0] rd_word;

  assign setup     = (|Pselx) && !Penable;
  assign paddr_idx = Paddr[WORD_LSB +: IDX_W];
  assign addr_err  = !$onehot(Pselx) || (Paddr[1:0] != 2'b00) || ((Paddr >> ADDR_HI) != '0);

  // With zero wait states READY is entered straight from the setup edge, so the
  // read path must look at the live bus instead of the latched copy.
  assign rd_sel = (state_q == ST_IDLE) ? Pselx : sel_q;
  assign rd_idx = (state_q == ST_IDLE) ? paddr_idx : idx_q;

  always_comb begin
    rd_word = '0;
    for (int s = 0; s < NUM_SLAVES; s++) begin
      if (rd_sel[s]) rd_word = rd_word | bank_rdata[s];
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    idx_d   = idx_q;
    write_d = write_q;
    err_d   = err_q;
    bank_we = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (setup) begin
          sel_d   = Pselx;
          idx_d   = paddr_idx;
          write_d = Pwrite;
          err_d   = addr_err;
          cnt_d   = CNT_W'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? ST_READY : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!(|Pselx)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (!(|Pselx)) begin
          state_d = ST_IDLE;
        end else if (Penable) begin
          state_d = ST_IDLE;
          bank_we = write_q && !err_q;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    pready_d  = (state_d == ST_READY);
    pslverr_d = (state_d == ST_READY) && err_d;
    prdata_d  = '0;
    if (state_d == ST_READY) begin
      if (state_q == ST_READY) prdata_d = prdata_q;
      else if (!write_d && !err_d) prdata_d = rd_word;
    end
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      sel_q     <= '0;
      idx_q     <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      idx_q     <= idx_d;
      write_q   <= write_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
    end
  end

  for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_bank
    apb_reg_bank #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (DEPTH)
    ) u_bank (
      .clk_i  (Hclk),
      .rst_ni (Hresetn),
      .we_i   (bank_we && sel_q[g]),
      .waddr_i(idx_q),
      .wdata_i(Pwdata),
      .raddr_i(rd_idx),
      .rdata_o(bank_rdata[g])
    );
  end

  assign Prdata  = prdata_q;
  assign Pready  = pready_q;
  assign Pslverr = pslverr_q;

endmodule
